// File: rtl/mlab_ram_cell.sv
`default_nettype none
// ============================================================================
// Module   : mlab_ram_cell
// Purpose  : LUT-RAM slice with a synchronous masked write port and an
//            asynchronous read port.
// Revision : 1.0 - initial release
// ============================================================================
module mlab_ram_cell #(
  parameter int    data_width                   = 1,
  parameter int    address_width                = 5,
  parameter int    logical_ram_depth            = 32,
  parameter int    first_address                = 0,
  parameter int    last_address                 = 31,
  parameter int    first_bit_number             = 0,
  parameter string logical_ram_name             = "lrmi",
  parameter int    logical_ram_width            = 20,
  parameter int    byte_enable_mask_width       = 1,
  parameter string mixed_port_feed_through_mode = "dont_care"
) (
  input  logic                              clk0,
  input  logic                              rst_n,
  input  logic                              ena0,
  input  logic [byte_enable_mask_width-1:0] portabyteenamasks,
  input  logic [data_width-1:0]             portadatain,
  input  logic [address_width-1:0]          portaaddr,
  input  logic [address_width-1:0]          portbaddr,
  output logic [data_width-1:0]             portbdataout
);

  localparam int c_slice_w = data_width / byte_enable_mask_width;
  localparam int c_idx_w   = (logical_ram_depth > 1) ? $clog2(logical_ram_depth) : 1;
  localparam bit c_mode_new = (mixed_port_feed_through_mode == "new");
  localparam bit c_mode_ok  = c_mode_new ||
                              (mixed_port_feed_through_mode == "old") ||
                              (mixed_port_feed_through_mode == "dont_care");
  localparam bit c_geom_ok  = (logical_ram_depth >= 1) &&
                              (logical_ram_depth <= (1 << address_width)) &&
                              (byte_enable_mask_width >= 1) &&
                              (data_width % byte_enable_mask_width == 0) &&
                              (first_address >= 0) &&
                              (last_address >= first_address) &&
                              (last_address - first_address + 1 <= logical_ram_depth);
  localparam bit c_info_ok  = (first_bit_number >= 0) && (logical_ram_width >= 1) &&
                              (logical_ram_name != "");

  generate
    if (!c_mode_ok) begin : g_bad_mode
      $error("mlab_ram_cell: illegal mixed_port_feed_through_mode");
    end
    if (!c_geom_ok || !c_info_ok) begin : g_bad_config
      $error("mlab_ram_cell: inconsistent geometry or descriptive parameters");
    end
  endgenerate

  logic [data_width-1:0] r_mem [logical_ram_depth];

  logic               w_wr_in_range;
  logic               w_rd_in_range;
  logic [c_idx_w-1:0] w_wr_idx;
  logic [c_idx_w-1:0] w_rd_idx;
  logic               w_feed_through;
  logic [data_width-1:0] w_rd_data;

  assign w_wr_in_range  = (int'(portaaddr) >= first_address) && (int'(portaaddr) <= last_address);
  assign w_rd_in_range  = (int'(portbaddr) >= first_address) && (int'(portbaddr) <= last_address);
  assign w_wr_idx       = c_idx_w'(int'(portaaddr) - first_address);
  assign w_rd_idx       = c_idx_w'(int'(portbaddr) - first_address);
  assign w_feed_through = ena0 && w_wr_in_range && (portaaddr == portbaddr);

  // Reset clears the whole array asynchronously so reads see zero at once.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < logical_ram_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (ena0 && w_wr_in_range) begin
      for (int k = 0; k < byte_enable_mask_width; k++) begin
        if (portabyteenamasks[k]) begin
          r_mem[w_wr_idx][k*c_slice_w +: c_slice_w] <= portadatain[k*c_slice_w +: c_slice_w];
        end
      end
    end
  end

  // In "new" mode a same-address write shows through before the edge.
  always_comb begin
    w_rd_data = '0;
    if (rst_n && w_rd_in_range) begin
      w_rd_data = r_mem[w_rd_idx];
      if (c_mode_new && w_feed_through) begin
        for (int k = 0; k < byte_enable_mask_width; k++) begin
          if (portabyteenamasks[k]) begin
            w_rd_data[k*c_slice_w +: c_slice_w] = portadatain[k*c_slice_w +: c_slice_w];
          end
        end
      end
    end
  end

  assign portbdataout = w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mlab_ram_cell.sv
`default_nettype none
// Bench for mlab_ram_cell: three instances (1-bit "new", 1-bit "dont_care",
// 4-bit two-slice window 8..15 "new") checked against an array model.
module tb_mlab_ram_cell;

  logic clk0 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk0 = ~clk0;

  logic       a_ena, a_mask, a_din;
  logic [4:0] a_wa, a_rb;
  logic       a_out, b_out;
  logic       c_ena;
  logic [1:0] c_mask;
  logic [3:0] c_din;
  logic [4:0] c_wa, c_rb;
  logic [3:0] c_out;

  mlab_ram_cell #(.mixed_port_feed_through_mode("new")) u_a (
    .clk0(clk0), .rst_n(rst_n), .ena0(a_ena), .portabyteenamasks(a_mask),
    .portadatain(a_din), .portaaddr(a_wa), .portbaddr(a_rb), .portbdataout(a_out));

  mlab_ram_cell #(.mixed_port_feed_through_mode("dont_care")) u_b (
    .clk0(clk0), .rst_n(rst_n), .ena0(a_ena), .portabyteenamasks(a_mask),
    .portadatain(a_din), .portaaddr(a_wa), .portbaddr(a_rb), .portbdataout(b_out));

  mlab_ram_cell #(
    .data_width(4), .address_width(5), .logical_ram_depth(8),
    .first_address(8), .last_address(15), .byte_enable_mask_width(2),
    .mixed_port_feed_through_mode("new")
  ) u_c (
    .clk0(clk0), .rst_n(rst_n), .ena0(c_ena), .portabyteenamasks(c_mask),
    .portadatain(c_din), .portaaddr(c_wa), .portbaddr(c_rb), .portbdataout(c_out));

  // Reference model: plain arrays indexed by the real address.
  bit         ref_ab [32];
  logic [3:0] ref_c  [int];

  typedef struct {
    int         which;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [3:0] c_bits(input logic [1:0] m);
    return {{2{m[1]}}, {2{m[0]}}};
  endfunction

  function automatic logic [3:0] model_ab(input bit new_mode);
    if (!rst_n) return 4'd0;
    if (new_mode && a_ena && a_mask && (a_wa == a_rb)) return {3'b000, a_din};
    return {3'b000, ref_ab[a_rb]};
  endfunction

  function automatic logic [3:0] model_c();
    logic [3:0] v;
    if (!rst_n || c_rb < 5'd8 || c_rb > 5'd15) return 4'd0;
    v = ref_c.exists(int'(c_rb)) ? ref_c[int'(c_rb)] : 4'd0;
    if (c_ena && (c_wa == c_rb)) v = (v & ~c_bits(c_mask)) | (c_din & c_bits(c_mask));
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_ab[i] = 1'b0;
    ref_c.delete();
  endtask

  // Queue expectations for the current inputs, let the monitor compare at the
  // falling edge, then commit the write into the model at the rising edge.
  task automatic step(input string tag);
    sb_q.push_back('{which: 0, exp: model_ab(1'b1), name: $sformatf("%s/A@%0d", tag, a_rb)});
    sb_q.push_back('{which: 1, exp: model_ab(1'b0), name: $sformatf("%s/B@%0d", tag, a_rb)});
    sb_q.push_back('{which: 2, exp: model_c(),      name: $sformatf("%s/C@%0d", tag, c_rb)});
    @(negedge clk0);
    @(posedge clk0);
    if (rst_n) begin
      if (a_ena && a_mask) ref_ab[a_wa] = a_din;
      if (c_ena && c_wa >= 5'd8 && c_wa <= 5'd15) begin
        ref_c[int'(c_wa)] = ((ref_c.exists(int'(c_wa)) ? ref_c[int'(c_wa)] : 4'd0) & ~c_bits(c_mask))
                            | (c_din & c_bits(c_mask));
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_ena = 1'b0; a_mask = 1'b1; a_din = 1'b0; a_wa = '0;
    c_ena = 1'b0; c_mask = 2'b11; c_din = '0; c_wa = '0;
  endtask

  task automatic read_sweep(input string tag);
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      a_rb = 5'(i);
      c_rb = 5'(i);
      step(tag);
    end
  endtask

  always @(negedge clk0) begin
    exp_t       e;
    logic [3:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.which)
        0:       act = {3'b000, a_out};
        1:       act = {3'b000, b_out};
        default: act = c_out;
      endcase
      checks++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    a_rb = 5'd3;
    c_rb = 5'd9;
    clear_model();
    #1;
    step("in_reset");
    checks++;
    if (a_out === 1'b0) passed++;
    else $display("FAIL in_reset direct: got %b expected 0", a_out);
    step("in_reset");
    rst_n = 1'b1;

    read_sweep("reset_sweep");

    // Fill 0..31 with addr[0]^addr[2]; C gets a derived 4-bit pattern.
    for (int i = 0; i < 32; i++) begin
      a_ena = 1'b1; a_mask = 1'b1; a_wa = 5'(i); a_din = 1'(i ^ (i >> 2));
      a_rb = 5'((i + 1) % 32);
      c_ena = 1'b1; c_mask = 2'b11; c_wa = 5'(i); c_din = 4'(i * 3 + 1); c_rb = 5'(i);
      step("fill");
    end
    read_sweep("readback");

    a_rb = 5'd5;
    #1;
    checks++;
    if (a_out === 1'b0) passed++;
    else $display("FAIL pattern addr5: got %b expected 0", a_out);
    a_rb = 5'd4;
    #1;
    checks++;
    if (a_out === 1'b1) passed++;
    else $display("FAIL pattern addr4: got %b expected 1", a_out);

    // Enable and mask gating on address 7.
    a_ena = 1'b1; a_mask = 1'b1; a_wa = 5'd7; a_din = 1'b1; a_rb = 5'd6;
    step("gate_set");
    a_ena = 1'b0; a_mask = 1'b1; a_din = 1'b0; a_rb = 5'd7;
    step("gate_ena0");
    a_ena = 1'b1; a_mask = 1'b0; a_din = 1'b0;
    step("gate_mask0");
    a_ena = 1'b0;
    step("gate_read");
    checks++;
    if (a_out === 1'b1) passed++;
    else $display("FAIL gate addr7: got %b expected 1", a_out);

    // Feed-through on address 3 (stored 0, writing 1).
    a_ena = 1'b1; a_mask = 1'b1; a_wa = 5'd3; a_din = 1'b0; a_rb = 5'd0;
    step("ft_clear");
    a_din = 1'b1; a_rb = 5'd3;
    #1;
    checks++;
    if (a_out === 1'b1) passed++;
    else $display("FAIL ft new before: got %b expected 1", a_out);
    checks++;
    if (b_out === 1'b0) passed++;
    else $display("FAIL ft dont_care before: got %b expected 0", b_out);
    step("ft_before");
    a_ena = 1'b0;
    step("ft_after");
    checks++;
    if (a_out === 1'b1 && b_out === 1'b1) passed++;
    else $display("FAIL ft after: got %b/%b expected 1/1", a_out, b_out);

    // Range window of C: 20 is outside, 8 is the first valid word.
    c_ena = 1'b1; c_mask = 2'b11; c_din = 4'hF; c_wa = 5'd20; c_rb = 5'd20;
    step("range_wr20");
    c_ena = 1'b0;
    step("range_rd20");
    checks++;
    if (c_out === 4'h0) passed++;
    else $display("FAIL range addr20: got %h expected 0", c_out);
    c_ena = 1'b1; c_din = 4'h1; c_wa = 5'd8; c_rb = 5'd8;
    step("range_wr8");
    c_ena = 1'b0;
    step("range_rd8");
    checks++;
    if (c_out === 4'h1) passed++;
    else $display("FAIL range addr8: got %h expected 1", c_out);

    for (int n = 0; n < 300; n++) begin
      a_ena  = 1'($urandom_range(0, 1));
      a_mask = 1'($urandom_range(0, 3) != 0);
      a_din  = 1'($urandom);
      a_wa   = 5'($urandom);
      a_rb   = ($urandom_range(0, 3) == 0) ? a_wa : 5'($urandom);
      c_ena  = 1'($urandom_range(0, 1));
      c_mask = 2'($urandom);
      c_din  = 4'($urandom);
      c_wa   = 5'($urandom_range(4, 19));
      c_rb   = ($urandom_range(0, 3) == 0) ? c_wa : 5'($urandom_range(4, 19));
      step("random");
    end

    // Reset pulled low between edges while a write is being offered.
    a_ena = 1'b1; a_mask = 1'b1; a_din = 1'b1; a_wa = 5'd4; a_rb = 5'd4;
    c_ena = 1'b1; c_mask = 2'b11; c_din = 4'hA; c_wa = 5'd10; c_rb = 5'd10;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out === 1'b0 && c_out === 4'h0) passed++;
    else $display("FAIL rst_mid immediate: got %b/%h expected 0/0", a_out, c_out);
    clear_model();
    step("rst_mid");
    step("rst_hold");
    rst_n = 1'b1;
    read_sweep("post_reset");

    @(negedge clk0);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    if (passed != checks) $display("FAIL: %0d checks failed", checks - passed);
    else $display("PASS");
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mlab_ram_cell.md
# mlab_ram_cell

Behavioural model of one MLAB LUT-RAM slice: a small simple-dual-port memory with a synchronous write port and an asynchronous (combinational) read port. It is the storage element inside the MLAB FIFO cell wrapper, where one instance is used per data bit (20 instances for a 20-bit FIFO). The wrapper supplies registered write data, address and enable, and registers the read data itself.

## Interface
- `data_width`, default 1: bits per word.
- `address_width`, default 5: width of both address ports.
- `logical_ram_depth`, default 32: number of words; must be ≤ 2^address_width.
- `first_address`, default 0: lowest valid address.
- `last_address`, default 31: highest valid address.
- `first_bit_number`, default 0: informational only; no functional effect.
- `logical_ram_name`, default "lrmi": informational only.
- `logical_ram_width`, default 20: informational only.
- `byte_enable_mask_width`, default 1: number of write-enable mask bits; must divide `data_width`.
- `mixed_port_feed_through_mode`, default "dont_care": legal values "new", "old", "dont_care".
- `clk0`  in  1  write clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena0`  in  1  write enable, sampled on rising `clk0`.
- `portabyteenamasks`  in  byte_enable_mask_width  per-slice write mask.
- `portadatain`  in  data_width  write data.
- `portaaddr`  in  address_width  write address.
- `portbaddr`  in  address_width  read address (combinational).
- `portbdataout`  out  data_width  read data.

## Operation
- Storage: array of `logical_ram_depth` words of `data_width` bits. Array index = address − `first_address`.
- Write: on rising `clk0`, if `rst_n` = 1, `ena0` = 1, and `first_address` ≤ `portaaddr` ≤ `last_address`, the word is updated. Each mask bit k enables bits [k*S +: S], where S = data_width/byte_enable_mask_width. Masked-off bits keep their value.
- Writes to out-of-range addresses are ignored.
- Read: `portbdataout` = mem[`portbaddr`] combinationally. An out-of-range `portbaddr` yields all zeros.
- Feed-through when `ena0` = 1, `portaaddr` == `portbaddr`, and the address is in range, before the clock edge:
  - "new": enabled slices show `portadatain`; masked-off slices show stored data.
  - "old" and "dont_care": stored data, identical behaviour.
- Reset: while `rst_n` = 0, all words clear to 0 immediately (asynchronously), writes are blocked, and `portbdataout` = 0.
- Any value other than the three legal `mixed_port_feed_through_mode` values is an elaboration error.

## Timing
- Write latency: data written at edge N is visible on `portbdataout` immediately after edge N (combinational path through the array), when `portbaddr` matches.
- Read latency: zero cycles; `portbdataout` follows `portbaddr` combinationally.
- No handshake. Back-to-back writes are allowed every cycle.
- A write at edge N followed by a read of the same address in cycle N+1 returns the new data in every mode.
- Reset assertion mid-cycle takes effect without waiting for a clock edge.
- A write is not performed at an edge where `rst_n` is low.
- After `rst_n` rises, the first write occurs at the next qualifying rising edge.
- `portbdataout` reset value: 0.

## Test plan
- Reset then read sweep: assert `rst_n` = 0, then release. Read all addresses 0..31 → every read returns 0.
- Fill and readback (data_width=1): write bit (addr[0]^addr[2]) to addr 0..31, one per cycle. Read 0..31 → pattern matches, e.g. addr 5 → 0, addr 4 → 1.
- Enable/mask gating: set addr 7 = 1. Then present din=0 at addr 7 twice, once with `ena0`=0 and once with mask=0, across edges → addr 7 still reads 1.
- Feed-through: addr 3 holds 0; `ena0`=1, din=1, `portaaddr`=`portbaddr`=3, before the edge:
  - "new" mode: output 1.
  - "dont_care" mode: output 0.
  - After the edge, both modes: output 1.
- Async reset mid-operation: with words written, pull `rst_n` low between clock edges → output 0 immediately. The concurrent `ena0`=1 edge is ignored. After release, all words read 0.
- Range limits (first_address=8, last_address=15, depth 8): write 1 to addr 20 → ignored; read addr 20 → 0. Write 1 to addr 8 → read addr 8 = 1.
